// File: rtl/crc16_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Package : crc16_pkg                                                         |
// | Shared CRC16 constants and checker state encoding.                          |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
package crc16_pkg;

   localparam logic [15:0] CRC_POLY        = 16'h1021;
   localparam logic [15:0] CRC_INIT        = 16'hFFFF;
   localparam logic [15:0] CHECK_123456789 = 16'h29B1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage : crc16_pkg
`default_nettype wire

// File: rtl/crc16_bit_step.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : crc16_bit_step                                                    |
// | One MSB-first, non-reflected CRC16 LFSR step (combinational).               |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module crc16_bit_step (
   input  logic [15:0] lfsr_in,
   input  logic        data_bit,
   input  logic [15:0] poly,
   output logic [15:0] lfsr_out
);

   logic feedback;

   assign feedback = lfsr_in[15] ^ data_bit;
   assign lfsr_out = {lfsr_in[14:0], 1'b0} ^ (feedback ? poly : 16'h0000);

endmodule : crc16_bit_step
`default_nettype wire

// File: rtl/crc16_frame_checker.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : crc16_frame_checker                                               |
// | Bit-serial CRC16 residue check over received frames, one byte per 9 clocks. |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module crc16_frame_checker
   import crc16_pkg::*;
#(
   parameter logic [15:0] POLY  = CRC_POLY,
   parameter logic [15:0] INIT  = CRC_INIT,
   parameter int          LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   input  logic             rx_last,
   output logic             rx_ready,
   output logic             frame_done,
   output logic             frame_ok,
   output logic [LEN_W-1:0] frame_len,
   output logic [15:0]      crc_value,
   output logic             busy
);

   state_t             state, state_nxt;
   logic [2:0]         bit_cnt;
   logic [7:0]         shreg;
   logic               last_flag;
   logic [LEN_W-1:0]   byte_cnt;
   logic [15:0]        lfsr;
   logic [15:0]        lfsr_step;
   logic               accept;

   crc16_bit_step u_bit_step (
      .lfsr_in  (lfsr),
      .data_bit (shreg[7]),
      .poly     (POLY),
      .lfsr_out (lfsr_step)
   );

   always_comb begin
      state_nxt = state;
      rx_ready  = 1'b0;
      case (state)
         IDLE: begin
            rx_ready = !rst;
            if (rx_valid && !rst) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (bit_cnt == 3'd7) state_nxt = last_flag ? DONE : IDLE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign accept    = rx_valid && rx_ready;
   assign crc_value = lfsr;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         lfsr       <= INIT;
         bit_cnt    <= 3'd0;
         shreg      <= 8'h00;
         last_flag  <= 1'b0;
         byte_cnt   <= '0;
         frame_done <= 1'b0;
         frame_ok   <= 1'b0;
         frame_len  <= '0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  shreg     <= rx_data;
                  last_flag <= rx_last;
                  bit_cnt   <= 3'd0;
                  busy      <= 1'b1;
                  // Length saturates rather than wrapping so oversize frames stay visible.
                  if (byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
               end
            end
            SHIFT: begin
               lfsr    <= lfsr_step;
               shreg   <= {shreg[6:0], 1'b0};
               bit_cnt <= bit_cnt + 3'd1;
            end
            DONE: begin
               // Frames of 1-2 bytes cannot carry a payload, so a zero residue is not trusted.
               frame_done <= 1'b1;
               frame_ok   <= (lfsr == 16'h0000) && (byte_cnt >= LEN_W'(3));
               frame_len  <= byte_cnt;
               lfsr       <= INIT;
               byte_cnt   <= '0;
               busy       <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule : crc16_frame_checker
`default_nettype wire
